// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM states, load/store
// operation codes, exception bit positions and bus size encodings.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_DRAIN
  } mem_state_e;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam int unsigned EXC_ADEL_BIT = 4;
  localparam int unsigned EXC_ADES_BIT = 5;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic [1:0] access_size(input logic [7:0] aluop);
    case (aluop)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: access_size = SIZE_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: access_size = SIZE_HALF;
      default:                          access_size = SIZE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: selects the byte/half lane of the captured read word
// by addr_lo and sign- or zero-extends it according to aluop.
// Ports: rbuf (captured read word), aluop, addr_lo (address bits [1:0]),
// data (aligned, extended 32-bit result).
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] rbuf,
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rbuf[7:0];
    case (addr_lo)
      2'd0: byte_lane = rbuf[7:0];
      2'd1: byte_lane = rbuf[15:8];
      2'd2: byte_lane = rbuf[23:16];
      2'd3: byte_lane = rbuf[31:24];
      default: byte_lane = rbuf[7:0];
    endcase
    half_lane = addr_lo[1] ? rbuf[31:16] : rbuf[15:0];

    data = rbuf;
    case (aluop)
      EXE_LB_OP:  data = {{24{byte_lane[7]}}, byte_lane};
      EXE_LBU_OP: data = {24'b0, byte_lane};
      EXE_LH_OP:  data = {{16{half_lane[15]}}, half_lane};
      EXE_LHU_OP: data = {16'b0, half_lane};
      default:    data = rbuf;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on the SRAM-like data
// bus, requests a pipeline stall while a transaction is outstanding, aligns
// load data and builds the MEM/WB payload.
// Ports: clk_i/rst_i (async active-high), stall_i/flush_i pipeline control,
// mem_* EX/MEM inputs, data_* bus, wb_* MEM/WB outputs, exception_type_o,
// stallreq_o.
// Build option: MEM_ADDR_EXC_EN enables alignment checks and AdEL/AdES;
// otherwise the bus address is forced aligned to the access size.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [4:0]        mem_wd_i,
  input  logic              mem_wreg_i,
  input  logic [63:0]       mem_wdata_i,
  input  logic              mem_rmem_i,
  input  logic              mem_wmem_i,
  input  logic [7:0]        mem_aluop_i,
  input  logic [31:0]       mem_mem_io_addr_i,
  input  logic [31:0]       mem_exception_type_i,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic [4:0]        wb_wd_o,
  output logic              wb_wreg_o,
  output logic [63:0]       wb_wdata_o,
  output logic [31:0]       exception_type_o,
  output logic              stallreq_o
);

  mem_state_e        state, state_n;
  logic [DATA_W-1:0] rbuf;
  logic              capture;
  logic              req;
  logic [1:0]        size;
  logic [31:0]       bus_addr;
  logic [31:0]       exc;
  logic              addr_exc;
  logic              valid;
  logic [31:0]       store_data;
  logic [31:0]       load_data;
`ifdef MEM_ADDR_EXC_EN
  logic              misaligned;
`endif

  always_comb size = access_size(mem_aluop_i);

  always_comb begin
    bus_addr = mem_mem_io_addr_i;
    exc      = mem_exception_type_i;
    addr_exc = 1'b0;
`ifdef MEM_ADDR_EXC_EN
    misaligned = ((size == SIZE_HALF) && mem_mem_io_addr_i[0]) ||
                 ((size == SIZE_WORD) && (mem_mem_io_addr_i[1:0] != 2'b00));
    if (mem_rmem_i && misaligned) exc[EXC_ADEL_BIT] = 1'b1;
    if (mem_wmem_i && misaligned) exc[EXC_ADES_BIT] = 1'b1;
    addr_exc = (mem_rmem_i || mem_wmem_i) && misaligned;
`else
    case (size)
      SIZE_WORD: bus_addr[1:0] = 2'b00;
      SIZE_HALF: bus_addr[0]   = 1'b0;
      default:   ;
    endcase
`endif
  end

  always_comb valid = (mem_rmem_i || mem_wmem_i) && (mem_exception_type_i == '0)
                      && !addr_exc && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      rbuf  <= '0;
    end else begin
      state <= state_n;
      if (capture) rbuf <= data_rdata_i;
    end
  end

  // A flush in DATA coinciding with data_ok ends the transaction outright;
  // only an unanswered flush needs DRAIN to swallow the late response.
  always_comb begin
    state_n    = state;
    req        = 1'b0;
    stallreq_o = 1'b0;
    capture    = 1'b0;
    case (state)
      ST_IDLE: begin
        req        = valid;
        stallreq_o = valid;
        if (valid) state_n = data_addr_ok_i ? ST_DATA : ST_ADDR;
      end
      ST_ADDR: begin
        stallreq_o = 1'b1;
        if (flush_i) begin
          state_n = ST_IDLE;
        end else begin
          req = 1'b1;
          if (data_addr_ok_i) state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        stallreq_o = 1'b1;
        if (data_data_ok_i) begin
          if (flush_i) begin
            state_n = ST_IDLE;
          end else begin
            capture = 1'b1;
            state_n = ST_DONE;
          end
        end else if (flush_i) begin
          state_n = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!stall_i || flush_i) state_n = ST_IDLE;
      end
      ST_DRAIN: begin
        stallreq_o = 1'b1;
        if (data_data_ok_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    case (size)
      SIZE_BYTE: store_data = {4{mem_wdata_i[7:0]}};
      SIZE_HALF: store_data = {2{mem_wdata_i[15:0]}};
      default:   store_data = mem_wdata_i[31:0];
    endcase
  end

  mem_load_align u_load_align (
    .rbuf    (rbuf[31:0]),
    .aluop   (mem_aluop_i),
    .addr_lo (bus_addr[1:0]),
    .data    (load_data)
  );

  always_comb begin
    data_req_o       = req;
    data_wr_o        = req && mem_wmem_i;
    data_size_o      = req ? size : '0;
    data_addr_o      = req ? ADDR_W'(bus_addr) : '0;
    data_wdata_o     = (req && mem_wmem_i) ? DATA_W'(store_data) : '0;
    wb_wd_o          = mem_wd_i;
    wb_wreg_o        = mem_wreg_i && (exc == '0) && !flush_i;
    wb_wdata_o       = mem_rmem_i ? {32'b0, load_data} : mem_wdata_i;
    exception_type_o = exc;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
  import mem_pkg::*;

  logic        clk, rst, stall, flush;
  logic [4:0]  wd;
  logic        wreg;
  logic [63:0] wdata;
  logic        rmem, wmem;
  logic [7:0]  aluop;
  logic [31:0] addr, exc_in;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] baddr, bwdata;
  logic        addr_ok, data_ok;
  logic [31:0] rdata;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [63:0] wb_wdata;
  logic [31:0] exc_out;
  logic        stallreq;

  mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .stall_i              (stall),
    .flush_i              (flush),
    .mem_wd_i             (wd),
    .mem_wreg_i           (wreg),
    .mem_wdata_i          (wdata),
    .mem_rmem_i           (rmem),
    .mem_wmem_i           (wmem),
    .mem_aluop_i          (aluop),
    .mem_mem_io_addr_i    (addr),
    .mem_exception_type_i (exc_in),
    .data_req_o           (req),
    .data_wr_o            (wr),
    .data_size_o          (size),
    .data_addr_o          (baddr),
    .data_wdata_o         (bwdata),
    .data_addr_ok_i       (addr_ok),
    .data_data_ok_i       (data_ok),
    .data_rdata_i         (rdata),
    .wb_wd_o              (wb_wd),
    .wb_wreg_o            (wb_wreg),
    .wb_wdata_o           (wb_wdata),
    .exception_type_o     (exc_out),
    .stallreq_o           (stallreq)
  );

  typedef struct {
    logic [7:0]  op;
    logic        rm, wm;
    logic [31:0] a;
    logic [63:0] wd64;
    logic [31:0] exci;
    logic [31:0] rd;
    int          aw, dw;
    logic        e_req;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [31:0] e_bw;
    logic        e_wr;
    logic        chk_wb;
    logic [63:0] e_wb;
    logic        e_wreg;
    logic [31:0] e_exc;
    int          e_stall;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  vec_t sb_q[$];

  int          a_wait = 0, d_wait = 0;
  logic [31:0] rdata_cfg = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic rm, input logic wm,
                              input logic [31:0] a, input logic [63:0] wd64,
                              input logic [31:0] exci, input logic [31:0] rd,
                              input int aw, input int dw, input logic e_req,
                              input logic [1:0] e_size, input logic [31:0] e_addr,
                              input logic [31:0] e_bw, input logic chk_wb,
                              input logic [63:0] e_wb, input logic e_wreg,
                              input logic [31:0] e_exc);
    vec_t v;
    v.op = op; v.rm = rm; v.wm = wm; v.a = a; v.wd64 = wd64; v.exci = exci;
    v.rd = rd; v.aw = aw; v.dw = dw; v.e_req = e_req; v.e_size = e_size;
    v.e_addr = e_addr; v.e_bw = e_bw; v.e_wr = wm && e_req; v.chk_wb = chk_wb;
    v.e_wb = e_wb; v.e_wreg = e_wreg; v.e_exc = e_exc;
    v.e_stall = e_req ? (aw + dw + 2) : 0;
    return v;
  endfunction

  // Bus slave: addr_ok after aw request cycles, data_ok dw cycles after the
  // first cycle following acceptance; rdata is junk outside data_ok.
  initial begin : bus_model
    int cnt, dcnt;
    bit phase;
    cnt = 0; dcnt = 0; phase = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h5A5A5A5A;
    forever begin
      @(posedge clk); #2;
      addr_ok = 1'b0; data_ok = 1'b0; rdata = 32'h5A5A5A5A;
      if (rst) begin
        phase = 1'b0; cnt = 0; dcnt = 0;
      end else if (!phase) begin
        if (req) begin
          if (cnt >= a_wait) begin
            addr_ok = 1'b1; phase = 1'b1; cnt = 0; dcnt = 0;
          end else cnt++;
        end else cnt = 0;
      end else begin
        if (dcnt >= d_wait) begin
          data_ok = 1'b1; rdata = rdata_cfg; phase = 1'b0;
        end else dcnt++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input vec_t v);
    aluop = v.op; rmem = v.rm; wmem = v.wm; addr = v.a; wdata = v.wd64;
    exc_in = v.exci; wreg = 1'b1; wd = 5'd7;
    rdata_cfg = v.rd; a_wait = v.aw; d_wait = v.dw;
  endtask

  task automatic idle_inputs();
    rmem = 1'b0; wmem = 1'b0; aluop = 8'h00; exc_in = '0; flush = 1'b0;
  endtask

  // Follows the front scoreboard entry until the DUT drops its stall request.
  task automatic complete(input string tag, input int max_cycles);
    vec_t e;
    int   stalls;
    bit   seen, done;
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_queue: got empty expected entry", tag);
      return;
    end
    e = sb_q[0];
    stalls = 0; seen = 1'b0; done = 1'b0;
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      if (req) begin
        seen = 1'b1;
        check({tag, "_size"},  64'(size),   64'(e.e_size));
        check({tag, "_addr"},  64'(baddr),  64'(e.e_addr));
        check({tag, "_wr"},    64'(wr),     64'(e.e_wr));
        check({tag, "_bwdata"}, 64'(bwdata), 64'(e.e_bw));
      end
      if (!stallreq) begin
        done = 1'b1;
        e = sb_q.pop_front();
        check({tag, "_req_seen"}, 64'(seen), 64'(e.e_req));
        if (e.e_stall >= 0) check({tag, "_stall_cycles"}, 64'(stalls), 64'(e.e_stall));
        if (e.chk_wb) check({tag, "_wb_wdata"}, wb_wdata, e.e_wb);
        check({tag, "_wb_wreg"}, 64'(wb_wreg), 64'(e.e_wreg));
        check({tag, "_exc"},     64'(exc_out), 64'(e.e_exc));
        check({tag, "_wb_wd"},   64'(wb_wd),   64'd7);
      end else begin
        stalls++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got stallreq=1 after %0d cycles expected release", tag, max_cycles);
      void'(sb_q.pop_front());
    end
  endtask

  initial begin : main
    vec_t v;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    wd = 5'd7; wreg = 1'b1; wdata = 64'h0123_4567_89AB_CDEF;
    rmem = 1'b0; wmem = 1'b0; aluop = 8'h00; addr = 32'h0; exc_in = '0;

    // Stimulus table: op, rm, wm, addr, wdata, exc_in, rdata, aw, dw,
    // then expected req, size, bus addr, bus wdata, chk_wb, wb, wreg, exc.
    vecs.push_back(mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 0, 32'hDEADBEEF, 0, 1,
                      1, SIZE_WORD, 32'h100, 32'h0, 1, 64'h0000_0000_DEAD_BEEF, 1, 0));
    vecs.push_back(mk(EXE_LB_OP, 1, 0, 32'h103, 64'h0, 0, 32'h80FF1234, 0, 0,
                      1, SIZE_BYTE, 32'h103, 32'h0, 1, 64'h0000_0000_FFFF_FF80, 1, 0));
    vecs.push_back(mk(EXE_LBU_OP, 1, 0, 32'h103, 64'h0, 0, 32'h80FF1234, 0, 0,
                      1, SIZE_BYTE, 32'h103, 32'h0, 1, 64'h0000_0000_0000_0080, 1, 0));
    vecs.push_back(mk(EXE_LH_OP, 1, 0, 32'h102, 64'h0, 0, 32'h80FF1234, 1, 0,
                      1, SIZE_HALF, 32'h102, 32'h0, 1, 64'h0000_0000_FFFF_80FF, 1, 0));
    vecs.push_back(mk(EXE_LHU_OP, 1, 0, 32'h100, 64'h0, 0, 32'h80FF1234, 0, 2,
                      1, SIZE_HALF, 32'h100, 32'h0, 1, 64'h0000_0000_0000_1234, 1, 0));
    vecs.push_back(mk(EXE_LB_OP, 1, 0, 32'h101, 64'h0, 0, 32'h00007F00, 1, 0,
                      1, SIZE_BYTE, 32'h101, 32'h0, 1, 64'h0000_0000_0000_007F, 1, 0));
    vecs.push_back(mk(EXE_SH_OP, 0, 1, 32'h202, 64'h1111_2222_0000_ABCD, 0, 32'h0, 0, 0,
                      1, SIZE_HALF, 32'h202, 32'hABCDABCD, 1, 64'h1111_2222_0000_ABCD, 1, 0));
    vecs.push_back(mk(EXE_SB_OP, 0, 1, 32'h301, 64'h0000_0000_0000_00EF, 0, 32'h0, 0, 0,
                      1, SIZE_BYTE, 32'h301, 32'hEFEFEFEF, 1, 64'h0000_0000_0000_00EF, 1, 0));
    vecs.push_back(mk(EXE_SW_OP, 0, 1, 32'h304, 64'h0000_0000_1234_5678, 0, 32'h0, 3, 1,
                      1, SIZE_WORD, 32'h304, 32'h12345678, 1, 64'h0000_0000_1234_5678, 1, 0));
    vecs.push_back(mk(8'h21, 0, 0, 32'h104, 64'hAAAA_5555_1234_5678, 0, 32'h0, 0, 0,
                      0, SIZE_BYTE, 32'h0, 32'h0, 1, 64'hAAAA_5555_1234_5678, 1, 0));
    vecs.push_back(mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 32'h100, 32'h0, 0, 0,
                      0, SIZE_WORD, 32'h0, 32'h0, 0, 64'h0, 0, 32'h100));
`ifdef MEM_ADDR_EXC_EN
    vecs.push_back(mk(EXE_LW_OP, 1, 0, 32'h101, 64'h0, 0, 32'hCAFEF00D, 0, 0,
                      0, SIZE_WORD, 32'h0, 32'h0, 0, 64'h0, 0, 32'h10));
    vecs.push_back(mk(EXE_SW_OP, 0, 1, 32'h206, 64'h0000_0000_CAFE_BABE, 0, 32'h0, 0, 0,
                      0, SIZE_WORD, 32'h0, 32'h0, 1, 64'h0000_0000_CAFE_BABE, 0, 32'h20));
    vecs.push_back(mk(EXE_LH_OP, 1, 0, 32'h103, 64'h0, 0, 32'hBEEF0000, 0, 0,
                      0, SIZE_HALF, 32'h0, 32'h0, 0, 64'h0, 0, 32'h10));
`else
    vecs.push_back(mk(EXE_LW_OP, 1, 0, 32'h101, 64'h0, 0, 32'hCAFEF00D, 0, 0,
                      1, SIZE_WORD, 32'h100, 32'h0, 1, 64'h0000_0000_CAFE_F00D, 1, 0));
    vecs.push_back(mk(EXE_SW_OP, 0, 1, 32'h206, 64'h0000_0000_CAFE_BABE, 0, 32'h0, 0, 0,
                      1, SIZE_WORD, 32'h204, 32'hCAFEBABE, 1, 64'h0000_0000_CAFE_BABE, 1, 0));
    vecs.push_back(mk(EXE_LH_OP, 1, 0, 32'h103, 64'h0, 0, 32'hBEEF0000, 0, 0,
                      1, SIZE_HALF, 32'h102, 32'h0, 1, 64'h0000_0000_FFFF_BEEF, 1, 0));
`endif

    // Reset state with no access presented, then a held load (rbuf is zero).
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req",      64'(req),      64'd0);
    check("rst_stallreq", 64'(stallreq), 64'd0);
    check("rst_addr",     64'(baddr),    64'd0);
    check("rst_size",     64'(size),     64'd0);
    check("rst_bwdata",   64'(bwdata),   64'd0);
    check("rst_wr",       64'(wr),       64'd0);
    check("rst_wb_wdata", wb_wdata,      64'h0123_4567_89AB_CDEF);
    check("rst_wb_wreg",  64'(wb_wreg),  64'd1);
    check("rst_exc",      64'(exc_out),  64'd0);
    rmem = 1'b1; aluop = EXE_LW_OP; addr = 32'h100; exc_in = 32'h1;
    #1;
    check("rst_rbuf_zero", wb_wdata,     64'd0);
    check("rst_exc_wreg",  64'(wb_wreg), 64'd0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
      complete($sformatf("v%0d", i), 40);
      @(posedge clk); #1;
      idle_inputs();
    end

    // Flush while in ADDR drops the request and returns to IDLE.
    @(posedge clk); #1;
    v = mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 0, 32'h0, 5, 0,
           1, SIZE_WORD, 32'h100, 32'h0, 0, 64'h0, 1, 0);
    drive(v);
    @(negedge clk); check("fa_req_c0", 64'(req), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); check("fa_req_c1", 64'(req), 64'd1);
    check("fa_addr_c1", 64'(baddr), 64'h100);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk); check("fa_req_drop", 64'(req), 64'd0);
    check("fa_wreg", 64'(wb_wreg), 64'd0);
    @(posedge clk); #1; idle_inputs();
    @(negedge clk); check("fa_idle_stall", 64'(stallreq), 64'd0);

    // Flush together with data_ok: straight to IDLE, next load issues at once.
    @(posedge clk); #1;
    v = mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 0, 32'h44444444, 0, 0,
           1, SIZE_WORD, 32'h100, 32'h0, 0, 64'h0, 1, 0);
    drive(v);
    @(negedge clk); check("fd_req_c0", 64'(req), 64'd1);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk); check("fd_wreg", 64'(wb_wreg), 64'd0);
    @(posedge clk); #1; flush = 1'b0;
    v = mk(EXE_LW_OP, 1, 0, 32'h300, 64'h0, 0, 32'h55555555, 0, 0,
           1, SIZE_WORD, 32'h300, 32'h0, 1, 64'h0000_0000_5555_5555, 1, 0);
    drive(v);
    sb_q.push_back(v);
    complete("fd_next", 20);
    @(posedge clk); #1; idle_inputs();

    // Flush in DATA, data_ok two cycles later: DRAIN blocks the next request.
    @(posedge clk); #1;
    v = mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 0, 32'h66666666, 0, 2,
           1, SIZE_WORD, 32'h100, 32'h0, 0, 64'h0, 1, 0);
    drive(v);
    @(negedge clk); check("dr_req_c0", 64'(req), 64'd1);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk); check("dr_stall_c1", 64'(stallreq), 64'd1);
    @(posedge clk); #1; flush = 1'b0; addr = 32'h200;
    @(negedge clk); check("dr_no_req_c2", 64'(req), 64'd0);
    check("dr_stall_c2", 64'(stallreq), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); check("dr_no_req_c3", 64'(req), 64'd0);
    @(posedge clk); #1;
    rdata_cfg = 32'h77777777; d_wait = 0;
    v = mk(EXE_LW_OP, 1, 0, 32'h200, 64'h0, 0, 32'h77777777, 0, 0,
           1, SIZE_WORD, 32'h200, 32'h0, 1, 64'h0000_0000_7777_7777, 1, 0);
    sb_q.push_back(v);
    complete("dr_next", 20);
    @(posedge clk); #1; idle_inputs();

    // Reset during DATA returns to IDLE immediately.
    @(posedge clk); #1;
    v = mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 0, 32'h11111111, 0, 6,
           1, SIZE_WORD, 32'h100, 32'h0, 0, 64'h0, 1, 0);
    drive(v);
    @(negedge clk); check("rd_req_c0", 64'(req), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rd_stall_in_rst", 64'(stallreq), 64'd0);
    check("rd_req_in_rst",   64'(req),      64'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    v = mk(EXE_LW_OP, 1, 0, 32'h100, 64'h0, 0, 32'h33333333, 0, 0,
           1, SIZE_WORD, 32'h100, 32'h0, 1, 64'h0000_0000_3333_3333, 1, 0);
    drive(v);
    sb_q.push_back(v);
    complete("rd_next", 20);
    @(posedge clk); #1; idle_inputs();

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage fed by the EX/MEM pipeline register. Issues loads and stores on the SRAM-like data bus, holds the pipeline while a transaction is outstanding, and aligns and extends load data. Detects misaligned-address exceptions and produces the write-back payload for the MEM/WB register.

## Interface
Parameters:
- `ADDR_W`, default 32: data bus address width.
- `DATA_W`, default 32: data bus data width.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `stall_i` in 1: MEM stage held by pipeline control.
- `flush_i` in 1: discard the instruction in MEM.
- `mem_wd_i` in 5: destination register.
- `mem_wreg_i` in 1: register write enable.
- `mem_wdata_i` in 64: ALU/HI-LO result; `[31:0]` is the store data.
- `mem_rmem_i` in 1: load.
- `mem_wmem_i` in 1: store.
- `mem_aluop_i` in 8: operation code.
- `mem_mem_io_addr_i` in 32: effective address.
- `mem_exception_type_i` in 32: exception bits from upstream.
- `data_req_o` out 1: bus request.
- `data_wr_o` out 1: 1 = store.
- `data_size_o` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr_o` out 32: bus address.
- `data_wdata_o` out 32: lane-replicated store data.
- `data_addr_ok_i` in 1: request accepted.
- `data_data_ok_i` in 1: response valid.
- `data_rdata_i` in 32: read data.
- `wb_wd_o` out 5: to MEM/WB.
- `wb_wreg_o` out 1: to MEM/WB.
- `wb_wdata_o` out 64: to MEM/WB.
- `exception_type_o` out 32: upstream bits plus AdEL (bit 4) or AdES (bit 5).
- `stallreq_o` out 1: stall request to pipeline control.

## Operation
- An access is valid when `mem_rmem_i` or `mem_wmem_i` is set, there is no upstream exception, there is no address exception, and `flush_i` is 0.
- Alignment rules:
  - `LH`, `LHU`, `SH` require `addr[0]` = 0.
  - `LW`, `SW` require `addr[1:0]` = 0.
  - A misaligned load sets bit 4; a misaligned store sets bit 5. No request is issued in either case.
- FSM states:
  - IDLE: `data_req_o` = valid access. On `addr_ok`, go to DATA; otherwise go to ADDR.
  - ADDR: `data_req_o` = 1, with address, size and data held stable. `addr_ok` goes to DATA. `flush_i` goes to IDLE and drops the request.
  - DATA: on `data_ok`, capture `rdata` into `rbuf` and go to DONE. On `flush_i` without `data_ok`, go to DRAIN.
  - DONE: `stallreq_o` = 0. When `stall_i` = 0, go to IDLE. When `flush_i` = 1, go to IDLE.
  - DRAIN: wait for `data_ok`, discard the data, go to IDLE. No new request is issued in this state.
- `stallreq_o` = 1 in IDLE (with a valid access), ADDR, DATA and DRAIN.
- Store data:
  - `SB`: byte replicated ×4.
  - `SH`: half replicated ×2.
  - `SW`: as-is.
- Load data: lane selected by `addr[1:0]` from `rbuf`.
  - `LB`/`LH`: sign-extended.
  - `LBU`/`LHU`: zero-extended.
  - The result lands in `wb_wdata_o[31:0]`, with `[63:32]` = 0.
- Non-load instructions: `wb_wdata_o` = `mem_wdata_i`.
- When `exception_type_o` ≠ 0 or `flush_i` = 1, `wb_wreg_o` = 0.

## Timing
- Reset value of state is IDLE and of `rbuf` is 0.
  - All outputs are combinational from state and inputs.
  - With no access presented, every output is 0 except the pass-throughs.
- Minimum load or store latency is 2 stall cycles:
  - Cycle 0: req + `addr_ok`.
  - Cycle 1: `data_ok`.
  - Cycle 2: DONE.
- Simultaneous `flush_i` and `data_ok` in DATA: the data is discarded and the FSM goes to IDLE (not DRAIN).
- Reset during ADDR, DATA or DRAIN: the FSM goes to IDLE immediately, and the bus is re-reset externally.
- `addr_ok` and `data_ok` in the same cycle are never presented; the bus guarantees at least 1 cycle between them.

## Configuration
- `MEM_ADDR_EXC_EN` defined: alignment checks and AdEL/AdES generation are active.
- Undefined:
  - No alignment check.
  - The address is forced aligned (`addr[1:0]` cleared for word, `addr[0]` for half).
  - `exception_type_o` = `mem_exception_type_i`.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum.
  - Load/store `aluop` codes `EXE_LB_OP` … `EXE_SW_OP`.
  - `EXC_ADEL_BIT` = 4, `EXC_ADES_BIT` = 5.
  - Size constants.
- Sub-module `mem_load_align`: combinational lane select and extension of `rbuf` by `aluop` and `addr[1:0]`.

## Test plan
- `LW` at 0x100, `addr_ok` at cycle 0, `data_ok` at cycle 2 with 0xDEADBEEF → `stallreq_o` high for cycles 0–2; `wb_wdata_o` = 0x00000000DEADBEEF.
- `LB` at 0x103 with `rdata` 0x80FF1234 → `wb_wdata_o[31:0]` = 0xFFFFFF80. `LBU` same address → 0x00000080.
- `SH` at 0x202 with data 0x0000ABCD → `data_size_o` = 1 and `data_wdata_o` = 0xABCDABCD.
- `LW` at 0x101 with the macro on → `data_req_o` stays 0, `exception_type_o[4]` = 1, `wb_wreg_o` = 0.
- `flush_i` in DATA, then `data_ok` 2 cycles later → FSM enters DRAIN; the next `LW` request is issued only after `data_ok`.
- `addr_ok` delayed 3 cycles → `data_addr_o` and `data_size_o` stay constant throughout ADDR.
